// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-side signals of the data cache, with modports for the cache (slave) and its environment (master)
interface dcache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  rd_en_i;
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;
    logic [31:0]           hit_count_o;
    logic [31:0]           miss_count_o;

    modport slave (
        input  rd_en_i, wr_en_i, addr_i, data_i, mem_rdata_i, mem_ack_i,
        output data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               hit_count_o, miss_count_o
    );

    modport master (
        output rd_en_i, wr_en_i, addr_i, data_i, mem_rdata_i, mem_ack_i,
        input  data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               hit_count_o, miss_count_o
    );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped write-through no-write-allocate data cache; define DCACHE_STATS_EN for hit/miss counters
module dcache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8
) (
    input logic     clk_i,
    input logic     rst_i,
    dcache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} stateT;

    stateT                 curState, nextState;
    logic [SETS-1:0]       lineValid;
    logic [TAG_W-1:0]      lineTag [SETS];
    logic [DATA_WIDTH-1:0] lineData [SETS];
    logic [DATA_WIDTH-1:0] respData;
    logic [IDX_W-1:0]      index;
    logic [TAG_W-1:0]      tag;
    logic                  hit, isRead, ackRd, ackWr;

    assign index  = bus.addr_i[IDX_W+1:2];
    assign tag    = bus.addr_i[ADDR_WIDTH-1:IDX_W+2];
    assign hit    = lineValid[index] && lineTag[index] == tag;
    assign isRead = bus.rd_en_i && !bus.wr_en_i;
    assign ackRd  = curState == RD_WAIT && bus.mem_ack_i;
    assign ackWr  = curState == WR_WAIT && bus.mem_ack_i;

    // The CPU holds its request stable while stalled, so the memory address and write data come straight from it
    assign bus.mem_addr_o  = bus.addr_i & ~ADDR_WIDTH'(3);
    assign bus.mem_wdata_o = bus.data_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) curState <= IDLE;
        else       curState <= nextState;
    end

    // Next-state and handshake outputs
    always_comb begin
        nextState     = curState;
        bus.stall_o   = 1'b0;
        bus.data_o    = '0;
        bus.mem_req_o = 1'b0;
        bus.mem_we_o  = 1'b0;
        case (curState)
            IDLE: begin
                if (bus.wr_en_i) begin
                    bus.stall_o = 1'b1;
                    nextState   = WR_WAIT;
                end else if (bus.rd_en_i) begin
                    bus.stall_o = !hit;
                    bus.data_o  = hit ? lineData[index] : '0;
                    nextState   = hit ? IDLE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                bus.stall_o   = 1'b1;
                bus.mem_req_o = 1'b1;
                nextState     = bus.mem_ack_i ? DONE : RD_WAIT;
            end
            WR_WAIT: begin
                bus.stall_o   = 1'b1;
                bus.mem_req_o = 1'b1;
                bus.mem_we_o  = 1'b1;
                nextState     = bus.mem_ack_i ? DONE : WR_WAIT;
            end
            default: begin
                bus.data_o = respData;
                nextState  = IDLE;
            end
        endcase
    end

    // Valid bits and response register; a write completion clears the response so DONE shows 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lineValid <= '0;
            respData  <= '0;
        end else if (ackRd) begin
            lineValid[index] <= 1'b1;
            respData         <= bus.mem_rdata_i;
        end else if (ackWr) begin
            respData <= '0;
        end
    end

    // Tag and data storage: fill on read miss, update on write hit, never allocate on write miss
    always_ff @(posedge clk_i) begin
        if (!rst_i && ackRd) begin
            lineTag[index]  <= tag;
            lineData[index] <= bus.mem_rdata_i;
        end else if (!rst_i && ackWr && hit) begin
            lineData[index] <= bus.data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hitCount, missCount;

    // Saturating hit/miss counters, reads only
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (curState == IDLE && isRead) begin
            if (hit && hitCount != '1)   hitCount  <= hitCount + 32'd1;
            if (!hit && missCount != '1) missCount <= missCount + 32'd1;
        end
    end

    assign bus.hit_count_o  = hitCount;
    assign bus.miss_count_o = missCount;
`else
    assign bus.hit_count_o  = '0;
    assign bus.miss_count_o = '0;
`endif
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized scoreboard bench for dcache against a tag-array/flat-memory reference model
module tb_dcache;
    localparam int SETS  = 8;
    localparam int IDX_W = 3;

    typedef struct {
        logic [31:0] data;
        int          req;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dcache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dcache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(SETS)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    expT         scb[$];
    int          checks = 0;
    int          errors = 0;
    int          reqSeen = 0;
    int          lastReq = 0;
    int          curDelay = 0;
    bit          forceAck = 1'b0;
    logic [31:0] expAddr = '0;
    logic [31:0] expWdata = '0;
    logic        expWe = 1'b0;
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] memArr [logic [31:0]];
    bit          refValid [SETS];
    logic [31:0] refTag [SETS];
    int          hitsM = 0;
    int          missesM = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] refVal(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] memVal(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : initVal(a);
    endfunction

    function automatic logic [31:0] statExp(input int v);
`ifdef DCACHE_STATS_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    // backing memory: acks after curDelay request cycles, checks the request it acknowledges
    initial begin
        int rc;
        rc = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = $urandom;
            if (forceAck) begin
                bus.mem_ack_i = 1'b1;
            end else if (bus.mem_req_o) begin
                if (rc == curDelay) begin
                    chk("mem_addr", bus.mem_addr_o, expAddr);
                    chk("mem_we", bus.mem_we_o, expWe);
                    if (bus.mem_we_o) begin
                        chk("mem_wdata", bus.mem_wdata_o, expWdata);
                        memArr[bus.mem_addr_o] = bus.mem_wdata_o;
                    end else begin
                        bus.mem_rdata_i = memVal(bus.mem_addr_o);
                    end
                    bus.mem_ack_i = 1'b1;
                    reqSeen++;
                    rc = 0;
                end else begin
                    rc++;
                end
            end else begin
                rc = 0;
            end
        end
    end

    // monitor: pops an expectation whenever an access completes, checks quiet outputs when idle
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((bus.rd_en_i || bus.wr_en_i) && !bus.stall_o) begin
                    if (scb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_response: got data %h with nothing pending, required no completion", bus.data_o);
                    end else begin
                        e = scb.pop_front();
                        chk("data_o", bus.data_o, e.data);
                        chk("mem_requests", reqSeen - lastReq, e.req);
                        lastReq = reqSeen;
                    end
                end else if (!bus.rd_en_i && !bus.wr_en_i) begin
                    chk("idle_stall", bus.stall_o, 1'b0);
                    chk("idle_data", bus.data_o, 32'd0);
                end
            end
        end
    end

    task automatic doOp(input bit isW, input bit both, input logic [31:0] a, input logic [31:0] d, input int dly);
        logic [31:0] wa, tg;
        int          idx, stalls, expStalls;
        bit          hit;
        expT         e;
        wa  = a & ~32'd3;
        idx = int'((a >> 2) % SETS);
        tg  = a >> (IDX_W + 2);
        hit = refValid[idx] && refTag[idx] == tg;
        if (isW) begin
            refMem[wa] = d;
            e.data     = '0;
            e.req      = 1;
            expStalls  = 2 + dly;
        end else begin
            e.data    = refVal(wa);
            e.req     = hit ? 0 : 1;
            expStalls = hit ? 0 : 2 + dly;
            if (hit) hitsM++;
            else begin
                missesM++;
                refValid[idx] = 1'b1;
                refTag[idx]   = tg;
            end
        end
        scb.push_back(e);
        curDelay    = dly;
        expAddr     = wa;
        expWe       = isW;
        expWdata    = d;
        bus.rd_en_i = !isW || both;
        bus.wr_en_i = isW;
        bus.addr_i  = a;
        bus.data_i  = isW ? d : $urandom;
        stalls      = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.stall_o) break;
            stalls++;
            if (stalls > 60) begin
                errors++;
                $display("FAIL stall_timeout: stall_o still high after %0d cycles, required release", stalls);
                break;
            end
        end
        chk("stall_cycles", stalls, expStalls);
        @(posedge clk);
        #1;
        bus.rd_en_i = 1'b0;
        bus.wr_en_i = 1'b0;
    endtask

    task automatic modelReset();
        foreach (refValid[i]) refValid[i] = 1'b0;
        hitsM   = 0;
        missesM = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        bus.rd_en_i = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.addr_i  = '0;
        bus.data_i  = '0;
        memArr[32'h100] = 32'hDEAD_BEEF;
        refMem[32'h100] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("reset_stall", bus.stall_o, 1'b0);
        chk("reset_req", bus.mem_req_o, 1'b0);
        chk("reset_we", bus.mem_we_o, 1'b0);
        chk("reset_data", bus.data_o, 32'd0);
        chk("reset_hits", bus.hit_count_o, 32'd0);
        chk("reset_misses", bus.miss_count_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        doOp(1'b0, 1'b0, 32'h100, '0, 2);
        doOp(1'b0, 1'b0, 32'h100, '0, 0);
        doOp(1'b1, 1'b0, 32'h100, 32'hCAFE_F00D, 0);
        doOp(1'b0, 1'b0, 32'h100, '0, 1);
        doOp(1'b1, 1'b1, 32'h200, 32'h0000_0055, 1);
        doOp(1'b0, 1'b0, 32'h200, '0, 0);
        doOp(1'b0, 1'b0, 32'h100, '0, 0);
        doOp(1'b0, 1'b0, 32'h120, '0, 3);
        doOp(1'b0, 1'b0, 32'h100, '0, 0);

        curDelay    = 1000;
        bus.rd_en_i = 1'b1;
        bus.addr_i  = 32'h104;
        @(negedge clk);
        @(negedge clk);
        chk("rdwait_req", bus.mem_req_o, 1'b1);
        chk("rdwait_stall", bus.stall_o, 1'b1);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.rd_en_i = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        forceAck = 1'b1;
        modelReset();
        @(negedge clk);
        chk("post_reset_req", bus.mem_req_o, 1'b0);
        chk("post_reset_stall", bus.stall_o, 1'b0);
        @(posedge clk);
        #1 forceAck = 1'b0;
        @(negedge clk);
        chk("late_ack_req", bus.mem_req_o, 1'b0);
        chk("late_ack_stall", bus.stall_o, 1'b0);
        @(posedge clk);
        #1;

        doOp(1'b0, 1'b0, 32'h100, '0, 1);
        repeat (3) doOp(1'b0, 1'b0, 32'h100, '0, 0);
        @(negedge clk);
        chk("stat_misses", bus.miss_count_o, statExp(1));
        chk("stat_hits", bus.hit_count_o, statExp(3));
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            bit          isW;
            logic [31:0] a;
            isW = $urandom_range(0, 2) == 0;
            a   = 32'h100 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            doOp(isW, isW && $urandom_range(0, 1) == 1, a, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        chk("final_misses", bus.miss_count_o, statExp(missesM));
        chk("final_hits", bus.hit_count_o, statExp(hitsM));
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", scb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
